// File: rtl/flux_sched_pkg.sv
// Shared types and index helpers for the round-robin flux scheduler.
// Pure declarations; no logic, no latency, no flow control of its own.
package flux_sched_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sched_st_e;

  function automatic int tag_width(input int flux);
    return (flux > 1) ? $clog2(flux) : 1;
  endfunction

  // Modulo-FLUX increment that also wraps correctly for non-power-of-2 FLUX.
  function automatic int wrap_inc(input int idx, input int flux);
    return (idx + 1 >= flux) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/flux_rr_pick.sv
// First-ready search starting at start_i and wrapping modulo FLUX.
// Purely combinational (zero latency); found_o=0 when nothing is ready.
module flux_rr_pick #(
  parameter int FLUX      = 2,
  parameter int TAG_WIDTH = 1
) (
  input  logic [FLUX-1:0]      ready_i,
  input  logic [TAG_WIDTH-1:0] start_i,
  output logic                 found_o,
  output logic [TAG_WIDTH-1:0] idx_o
);

  // Scan offsets from the far end so the nearest ready index is written last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = FLUX - 1; k >= 0; k--) begin
      if (ready_i[(int'(start_i) + k) % FLUX]) begin
        found_o = 1'b1;
        idx_o   = TAG_WIDTH'((int'(start_i) + k) % FLUX);
      end
    end
  end

endmodule

// File: rtl/flux_rr_scheduler.sv
// Round-robin scheduler with a per-flux burst quota for one shared two-operand actor.
// Strobes are combinational from FIFO status; FIFO empty/full simply removes a flux from selection.
module flux_rr_scheduler
  import flux_sched_pkg::*;
#(
  parameter int FLUX      = 2,
  parameter int BURST     = 4,
  parameter int TAG_WIDTH = tag_width(FLUX)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [FLUX-1:0]      empty_a,
  input  logic [FLUX-1:0]      empty_b,
  input  logic [FLUX-1:0]      full,
  output logic [FLUX-1:0]      read_a,
  output logic [FLUX-1:0]      read_b,
  output logic                 write,
  output logic [TAG_WIDTH-1:0] tag,
  output logic                 locked
);

  localparam int             CW      = $clog2(BURST + 1);
  localparam logic [CW-1:0]  BURST_C = CW'(BURST);

  sched_st_e            st_q, st_d;
  logic [TAG_WIDTH-1:0] cur_q, cur_d;
  logic [TAG_WIDTH-1:0] ptr_q, ptr_d;
  logic [CW-1:0]        bcnt_q, bcnt_d;
  logic [CW-1:0]        cnt_nx;

  logic [FLUX-1:0]      ready;
  logic [TAG_WIDTH-1:0] start;
  logic [TAG_WIDTH-1:0] pick_idx;
  logic [TAG_WIDTH-1:0] sel;
  logic [TAG_WIDTH-1:0] sel_inc;
  logic [TAG_WIDTH-1:0] cur_inc;
  logic                 found;
  logic                 keep;
  logic                 fire;

  assign ready   = ~empty_a & ~empty_b & ~full & {FLUX{enable}};
  assign cur_inc = TAG_WIDTH'(wrap_inc(int'(cur_q), FLUX));
  assign sel_inc = TAG_WIDTH'(wrap_inc(int'(sel), FLUX));

  // A locked flux keeps the grant while ready; otherwise search resumes just past it.
  assign keep  = (st_q == LOCKED) && ready[cur_q];
  assign start = (st_q == LOCKED) ? cur_inc : ptr_q;

  flux_rr_pick #(
    .FLUX      (FLUX),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_pick (
    .ready_i (ready),
    .start_i (start),
    .found_o (found),
    .idx_o   (pick_idx)
  );

  assign sel  = keep ? cur_q : pick_idx;
  assign fire = keep || found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      cur_q  <= '0;
      ptr_q  <= '0;
      bcnt_q <= '0;
    end else begin
      st_q   <= st_d;
      cur_q  <= cur_d;
      ptr_q  <= ptr_d;
      bcnt_q <= bcnt_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    cur_d  = cur_q;
    ptr_d  = ptr_q;
    bcnt_d = bcnt_q;
    cnt_nx = ((st_q == LOCKED) && (sel == cur_q)) ? bcnt_q + 1'b1 : CW'(1);
    if (fire) begin
      cur_d = sel;
      if (cnt_nx == BURST_C) begin
        st_d   = IDLE;
        ptr_d  = sel_inc;
        bcnt_d = '0;
      end else begin
        st_d   = LOCKED;
        bcnt_d = cnt_nx;
      end
    end else if (enable && (st_q == LOCKED)) begin
      // Nothing ready: give up the lock so the next search starts after cur.
      st_d   = IDLE;
      ptr_d  = cur_inc;
      bcnt_d = '0;
    end
  end

  always_comb begin
    read_a = '0;
    read_b = '0;
    write  = 1'b0;
    tag    = '0;
    if (fire && !rst) begin
      read_a[sel] = 1'b1;
      read_b[sel] = 1'b1;
      write       = 1'b1;
      tag         = sel;
    end
  end

  assign locked = (st_q == LOCKED);

endmodule
